// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb / blast / collision blocks.
// Holds the controller state type, off-screen sentinels and the grid-snap rule.
package bomb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [10:0] OFFSCREEN_X  = 11'd640;
  localparam logic [10:0] OFFSCREEN_Y  = 11'd480;
  localparam int          WAIT_TIMEOUT = 4;

  // Round to the nearest grid line: add half a tile, then clear the low bits.
  // The sum is 12 bits wide and the result wraps to 11 bits.
  function automatic logic [10:0] snap(input logic [10:0] pos, input int tile);
    logic [11:0] sum;
    logic [11:0] mask;
    logic [11:0] snapped;
    sum     = {1'b0, pos} + 12'(tile / 2);
    mask    = ~(12'(tile) - 12'd1);
    snapped = sum & mask;
    return snapped[10:0];
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with a registered one-cycle pulse output.
// The pulse appears the cycle after the input is first seen high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q  <= 1'b0;
      rise <= 1'b0;
    end else begin
      d_q  <= d;
      rise <= d & ~d_q;
    end
  end

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb placement and fuse controller: places a grid-snapped bomb, counts the fuse,
// fires a one-cycle blast pulse and waits for the blast block's explode window.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_SECONDS = 3,
  parameter int TILE         = 32,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        OneSecPulse,
  input  logic        startOfFrame,
  input  logic        place_req,
  input  logic [10:0] player_topLeftX,
  input  logic [10:0] player_topLeftY,
  input  logic        chain_hit,
  input  logic        explode,
  output logic        blast,
  output logic [10:0] bomb_topLeftX,
  output logic [10:0] bomb_topLeftY,
  output logic        bomb_visible,
  output logic        busy
);

  localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               place_rise;
  logic [2:0]         fuse;
  logic [FLASH_W-1:0] flash_cnt;
  logic               flash_off;
  logic [2:0]         wait_cnt;
  logic               seen_explode;
  logic               fuse_done;
  logic               explode_done;
  logic               watchdog;

  rise_detect u_place_edge (
    .clk   (clk),
    .reset (reset),
    .d     (place_req),
    .rise  (place_rise)
  );

  assign fuse_done    = OneSecPulse && (fuse == 3'd1);
  assign explode_done = seen_explode && !explode;
  // The FIRE cycle counts as the first watchdog cycle, so WAIT gives up
  // WAIT_TIMEOUT cycles after the blast pulse.
  assign watchdog     = !seen_explode && !explode && (wait_cnt >= 3'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (place_rise) state_nxt = S_ARMED;
      S_ARMED: if (chain_hit || fuse_done) state_nxt = S_FIRE;
      S_FIRE:  state_nxt = S_WAIT;
      S_WAIT:  if (explode_done || watchdog) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fuse <= 3'd0;
    end else if (state == S_IDLE && place_rise) begin
      fuse <= 3'(FUSE_SECONDS);
    end else if (state == S_ARMED) begin
      if (OneSecPulse && !chain_hit && fuse != 3'd0) fuse <= fuse - 3'd1;
    end else begin
      fuse <= 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bomb_topLeftX <= OFFSCREEN_X;
      bomb_topLeftY <= OFFSCREEN_Y;
    end else if (state == S_IDLE && place_rise) begin
      bomb_topLeftX <= snap(player_topLeftX, TILE);
      bomb_topLeftY <= snap(player_topLeftY, TILE);
    end else if (state == S_WAIT && state_nxt == S_IDLE) begin
      bomb_topLeftX <= OFFSCREEN_X;
      bomb_topLeftY <= OFFSCREEN_Y;
    end
  end

  // Warning flash runs only in the last fuse second; visibility starts on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt <= '0;
      flash_off <= 1'b0;
    end else if (state == S_ARMED && fuse == 3'd1) begin
      if (startOfFrame) begin
        if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
          flash_cnt <= '0;
          flash_off <= ~flash_off;
        end else begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end
    end else begin
      flash_cnt <= '0;
      flash_off <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt     <= 3'd0;
      seen_explode <= 1'b0;
    end else if (state == S_FIRE) begin
      wait_cnt     <= 3'd1;
      seen_explode <= 1'b0;
    end else if (state == S_WAIT) begin
      if (wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
      seen_explode <= seen_explode | explode;
    end else begin
      wait_cnt     <= 3'd0;
      seen_explode <= 1'b0;
    end
  end

  assign blast        = (state == S_FIRE);
  assign busy         = (state != S_IDLE);
  assign bomb_visible = (state == S_ARMED) && !flash_off;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Self-checking bench for bomb_ctrl: snap table, directed handshake sequences,
// randomized fuse/chain/explode scenarios against a timeline model, flash and reset.
module tb_bomb_ctrl;

  localparam int FUSE  = 3;
  localparam int TILE  = 32;
  localparam int FLASH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        OneSecPulse = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        place_req = 1'b0;
  logic [10:0] player_topLeftX = 11'd0;
  logic [10:0] player_topLeftY = 11'd0;
  logic        chain_hit = 1'b0;
  logic        explode = 1'b0;
  logic        blast;
  logic [10:0] bomb_topLeftX;
  logic [10:0] bomb_topLeftY;
  logic        bomb_visible;
  logic        busy;

  int total = 0;
  int bad = 0;
  int blast_cnt = 0;

  typedef struct {
    int x;
    int y;
    int ex;
    int ey;
  } snap_vec_t;

  snap_vec_t vecs[8];

  bomb_ctrl #(.FUSE_SECONDS(FUSE), .TILE(TILE), .FLASH_FRAMES(FLASH)) dut (
    .clk             (clk),
    .reset           (reset),
    .OneSecPulse     (OneSecPulse),
    .startOfFrame    (startOfFrame),
    .place_req       (place_req),
    .player_topLeftX (player_topLeftX),
    .player_topLeftY (player_topLeftY),
    .chain_hit       (chain_hit),
    .explode         (explode),
    .blast           (blast),
    .bomb_topLeftX   (bomb_topLeftX),
    .bomb_topLeftY   (bomb_topLeftY),
    .bomb_visible    (bomb_visible),
    .busy            (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (blast === 1'b1) blast_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_all(input string tag, input logic eb, input logic ev,
                            input logic ebusy, input int ex, input int ey);
    chk({tag, "_blast"}, 32'(blast), 32'(eb));
    chk({tag, "_vis"}, 32'(bomb_visible), 32'(ev));
    chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
    chk({tag, "_x"}, 32'(bomb_topLeftX), ex);
    chk({tag, "_y"}, 32'(bomb_topLeftY), ey);
  endtask

  function automatic int snap_ref(input int v);
    return (((v + TILE / 2) / TILE) * TILE) % 2048;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input int x, input int y, input int ex, input int ey);
    player_topLeftX = 11'(x);
    player_topLeftY = 11'(y);
    place_req = 1'b1;
    step();
    expect_all("place_gap", 1'b0, 1'b0, 1'b0, 640, 480);
    step();
    place_req = 1'b0;
    expect_all("place", 1'b0, 1'b1, 1'b1, ex, ey);
  endtask

  task automatic pulse();
    OneSecPulse = 1'b1;
    step();
    OneSecPulse = 1'b0;
  endtask

  // Called in the blast cycle with explode never raised.
  task automatic watchdog_idle(input int ex, input int ey);
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_all("wd_wait", 1'b0, 1'b0, 1'b1, ex, ey);
    end
    step();
    expect_all("wd_idle", 1'b0, 1'b0, 1'b0, 640, 480);
  endtask

  // Called in the blast cycle: explode rises next cycle for n cycles.
  task automatic explode_handshake(input int n, input int ex, input int ey);
    step();
    expect_all("ex_first", 1'b0, 1'b0, 1'b1, ex, ey);
    explode = 1'b1;
    for (int k = 0; k < n; k++) step();
    explode = 1'b0;
    expect_all("ex_fall", 1'b0, 1'b0, 1'b1, ex, ey);
    step();
    expect_all("ex_idle", 1'b0, 1'b0, 1'b0, 640, 480);
  endtask

  task automatic run_random(input int count);
    for (int s = 0; s < count; s++) begin
      int x, y, ex, ey, pulses, guard, d, len, last;
      bit done, p, c, e;
      x = $urandom_range(0, 2047);
      y = $urandom_range(0, 2047);
      ex = snap_ref(x);
      ey = snap_ref(y);
      pulses = 0;
      guard = 0;
      done = 1'b0;
      place(x, y, ex, ey);
      while (!done && guard < 300) begin
        p = ($urandom_range(0, 3) == 0);
        c = ($urandom_range(0, 29) == 0);
        OneSecPulse = p;
        chain_hit = c;
        if (c || (p && pulses + 1 == FUSE)) done = 1'b1;
        else if (p) pulses++;
        step();
        OneSecPulse = 1'b0;
        chain_hit = 1'b0;
        guard++;
        if (done) expect_all("rnd_blast", 1'b1, 1'b0, 1'b1, ex, ey);
        else      expect_all("rnd_armed", 1'b0, 1'b1, 1'b1, ex, ey);
      end
      chk("rnd_detonated", 32'(done), 32'd1);
      d = $urandom_range(1, 3);
      len = $urandom_range(0, 5);
      if (len == 0) begin
        watchdog_idle(ex, ey);
      end else begin
        last = d + len + 1;
        for (int k = 1; k <= last; k++) begin
          e = (k - 1 >= d) && (k - 1 < d + len);
          explode = e;
          step();
          if (k < last) expect_all("rnd_wait", 1'b0, 1'b0, 1'b1, ex, ey);
          else          expect_all("rnd_idle", 1'b0, 1'b0, 1'b0, 640, 480);
        end
        explode = 1'b0;
      end
    end
  endtask

  task automatic run_flash_and_reset();
    int sof_cnt;
    bit sof;
    place(50, 60, 64, 64);
    for (int k = 0; k < 20; k++) begin
      startOfFrame = ($urandom_range(0, 1) == 1);
      step();
      expect_all("flash_f3", 1'b0, 1'b1, 1'b1, 64, 64);
    end
    startOfFrame = 1'b0;
    pulse();
    for (int k = 0; k < 20; k++) begin
      startOfFrame = ($urandom_range(0, 1) == 1);
      step();
      expect_all("flash_f2", 1'b0, 1'b1, 1'b1, 64, 64);
    end
    startOfFrame = 1'b0;
    pulse();
    sof_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      sof = ($urandom_range(0, 1) == 1);
      startOfFrame = sof;
      step();
      if (sof) sof_cnt++;
      expect_all("flash_f1", 1'b0, ((sof_cnt / FLASH) % 2) == 0, 1'b1, 64, 64);
    end
    startOfFrame = 1'b0;
    reset = 1'b1;
    #1;
    expect_all("reset_mid", 1'b0, 1'b0, 1'b0, 640, 480);
    step();
    reset = 1'b0;
    step();
    expect_all("reset_after", 1'b0, 1'b0, 1'b0, 640, 480);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b0;
    vecs[0] = '{x: 100,  y: 200,  ex: 96,   ey: 192};
    vecs[1] = '{x: 0,    y: 0,    ex: 0,    ey: 0};
    vecs[2] = '{x: 15,   y: 15,   ex: 0,    ey: 0};
    vecs[3] = '{x: 16,   y: 16,   ex: 32,   ey: 32};
    vecs[4] = '{x: 639,  y: 479,  ex: 640,  ey: 480};
    vecs[5] = '{x: 2047, y: 2047, ex: 0,    ey: 0};
    vecs[6] = '{x: 1000, y: 1023, ex: 992,  ey: 1024};
    vecs[7] = '{x: 2030, y: 100,  ex: 2016, ey: 96};

    step();
    expect_all("reset", 1'b0, 1'b0, 1'b0, 640, 480);
    reset = 1'b0;
    step();
    step();
    expect_all("idle", 1'b0, 1'b0, 1'b0, 640, 480);

    // placement snap and fuse expiry with a full explode handshake
    b0 = blast_cnt;
    place(100, 200, 96, 192);
    step();
    step();
    pulse();
    expect_all("fuse_1", 1'b0, 1'b1, 1'b1, 96, 192);
    step();
    pulse();
    expect_all("fuse_2", 1'b0, 1'b1, 1'b1, 96, 192);
    step();
    step();
    pulse();
    expect_all("fuse_blast", 1'b1, 1'b0, 1'b1, 96, 192);
    explode_handshake(10, 96, 192);
    chk("fuse_blast_once", 32'(blast_cnt - b0), 32'd1);

    // chain hit after one second, then watchdog return
    place(300, 50, 288, 64);
    pulse();
    step();
    step();
    chain_hit = 1'b1;
    step();
    chain_hit = 1'b0;
    expect_all("chain_blast", 1'b1, 1'b0, 1'b1, 288, 64);
    watchdog_idle(288, 64);

    // chain hit coincident with the final second
    b0 = blast_cnt;
    place(0, 0, 0, 0);
    pulse();
    pulse();
    OneSecPulse = 1'b1;
    chain_hit = 1'b1;
    step();
    OneSecPulse = 1'b0;
    chain_hit = 1'b0;
    expect_all("coinc_blast", 1'b1, 1'b0, 1'b1, 0, 0);
    explode_handshake(3, 0, 0);
    chk("coinc_blast_once", 32'(blast_cnt - b0), 32'd1);

    // placement lockout in ARMED and WAIT, held key across idle
    place(100, 200, 96, 192);
    step();
    player_topLeftX = 11'd400;
    player_topLeftY = 11'd400;
    place_req = 1'b1;
    step();
    step();
    step();
    place_req = 1'b0;
    step();
    expect_all("lock_armed", 1'b0, 1'b1, 1'b1, 96, 192);
    pulse();
    pulse();
    pulse();
    expect_all("lock_blast", 1'b1, 1'b0, 1'b1, 96, 192);
    place_req = 1'b1;
    step();
    step();
    step();
    expect_all("lock_wait", 1'b0, 1'b0, 1'b1, 96, 192);
    step();
    expect_all("lock_idle", 1'b0, 1'b0, 1'b0, 640, 480);
    step();
    step();
    expect_all("lock_held", 1'b0, 1'b0, 1'b0, 640, 480);
    place_req = 1'b0;
    step();
    place(400, 400, 416, 416);
    chain_hit = 1'b1;
    step();
    chain_hit = 1'b0;
    expect_all("lock_new_blast", 1'b1, 1'b0, 1'b1, 416, 416);
    watchdog_idle(416, 416);

    // snap table
    for (int i = 0; i < 8; i++) begin
      place(vecs[i].x, vecs[i].y, vecs[i].ex, vecs[i].ey);
      chain_hit = 1'b1;
      step();
      chain_hit = 1'b0;
      expect_all("tbl_blast", 1'b1, 1'b0, 1'b1, vecs[i].ex, vecs[i].ey);
      watchdog_idle(vecs[i].ex, vecs[i].ey);
    end

    run_random(25);
    run_flash_and_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
